// File: rtl/writeback.sv
// writeback -- final pipeline stage: buffers execute results in a 2-entry FIFO and
// commits them in order as register-file writes or acked memory stores. (rev 1.0)
`default_nettype none

module writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int RETIRE_WIDTH  = 16,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_res_valid,
    input  logic [7:0]               i_opcode,
    input  logic [DATA_WIDTH-1:0]    i_res,
    input  logic [3:0]               i_dest_reg,
    input  logic [ADDRESS_WIDTH-1:0] i_dest_addr,
    output logic                     o_ready,
    output logic                     o_rf_we,
    output logic [3:0]               o_rf_waddr,
    output logic [DATA_WIDTH-1:0]    o_rf_wdata,
    output logic                     o_mem_req,
    output logic [ADDRESS_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]    o_mem_wdata,
    input  logic                     i_mem_ack,
    output logic [RETIRE_WIDTH-1:0]  o_retire_count,
    output logic                     o_mem_err,
    output logic                     o_busy
);

    localparam int PKT_W = 8 + DATA_WIDTH + 4 + ADDRESS_WIDTH;
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REG_WR  = 2'd1;
    localparam logic [1:0] ST_MEM_REQ = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [PKT_W-1:0]         fifo_q [2];
    logic                     wptr_q, rptr_q;
    logic [1:0]               count_q, count_d;
    logic                     ready_q, ready_d;
    logic                     push, pop;
    logic                     want_next, retire_cur, tmo_hit;
    logic                     dec_nop, dec_reg, dec_st;
    logic [7:0]               h_op;
    logic [DATA_WIDTH-1:0]    h_res;
    logic [3:0]               h_reg;
    logic [ADDRESS_WIDTH-1:0] h_addr;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic [3:0]               rf_waddr_q;
    logic [DATA_WIDTH-1:0]    rf_wdata_q;
    logic                     rf_en_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic [RETIRE_WIDTH-1:0]  retire_q, retire_d;
    logic                     mem_err_q;

    assign push = i_res_valid && ready_q;
    assign {h_op, h_res, h_reg, h_addr} = fifo_q[rptr_q];

    // The packet being committed lives in the working registers; the FIFO holds
    // only the packets queued behind it, so a steady stream never fills it.
    always_comb begin
        state_d    = state_q;
        want_next  = 1'b0;
        retire_cur = 1'b0;
        tmo_hit    = 1'b0;
        case (state_q)
            ST_IDLE: want_next = 1'b1;
            ST_REG_WR: begin
                want_next  = 1'b1;
                retire_cur = 1'b1;
            end
            ST_MEM_REQ: begin
                if (i_mem_ack) begin
                    want_next  = 1'b1;
                    retire_cur = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    want_next = 1'b1;
                    tmo_hit   = 1'b1;
                end
            end
            default: want_next = 1'b1;
        endcase
        pop     = want_next && (count_q != 2'd0);
        dec_nop = pop && (h_op == 8'h00);
        dec_st  = pop && h_op[7];
        dec_reg = pop && !dec_nop && !dec_st;
        if (want_next) begin
            if (dec_reg) begin
                state_d = ST_REG_WR;
            end else if (dec_st) begin
                state_d = ST_MEM_REQ;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        ready_d  = (count_d != 2'd2);
        retire_d = retire_q + RETIRE_WIDTH'(retire_cur) + RETIRE_WIDTH'(dec_nop);
        tmo_d    = tmo_q;
        if (dec_st) begin
            tmo_d = '0;
        end else if (state_q == ST_MEM_REQ) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        o_rf_we   = (state_q == ST_REG_WR) && rf_en_q;
        o_mem_req = (state_q == ST_MEM_REQ);
        o_busy    = (state_q != ST_IDLE) || (count_q != 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= 2'd0;
            ready_q     <= 1'b0;
            tmo_q       <= '0;
            rf_waddr_q  <= 4'd0;
            rf_wdata_q  <= '0;
            rf_en_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            retire_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            ready_q   <= ready_d;
            tmo_q     <= tmo_d;
            retire_q  <= retire_d;
            mem_err_q <= mem_err_q | tmo_hit;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            if (dec_reg) begin
                rf_waddr_q <= h_reg;
                rf_wdata_q <= h_res;
                // Register 0 is hardwired zero: the write still retires but never strobes.
                rf_en_q    <= (h_reg != 4'd0);
            end
            if (dec_st) begin
                mem_addr_q  <= h_addr;
                mem_wdata_q <= h_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {i_opcode, i_res, i_dest_reg, i_dest_addr};
        end
    end

    assign o_ready        = ready_q;
    assign o_rf_waddr     = rf_waddr_q;
    assign o_rf_wdata     = rf_wdata_q;
    assign o_mem_addr     = mem_addr_q;
    assign o_mem_wdata    = mem_wdata_q;
    assign o_retire_count = retire_q;
    assign o_mem_err      = mem_err_q;

endmodule

`default_nettype wire

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage, directly downstream of the execute stage.
- Consumes result packets (opcode, result, destination register/address) over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Commits each packet in order: either a single-cycle register-file write, or a memory store with a req/ack handshake and ack timeout.
- Maintains a retired-instruction counter and a sticky memory-error flag.

Parameters:
- DATA_WIDTH, 32: result / write-data width.
- ADDRESS_WIDTH, 16: memory address width.
- RETIRE_WIDTH, 16: retire counter width.
- MEM_TIMEOUT, 16: max cycles o_mem_req waits for i_mem_ack before the entry is dropped.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_res_valid  in  1  execute stage holds a valid result packet.
- i_opcode  in  8  opcode of the packet.
- i_res  in  DATA_WIDTH  result data.
- i_dest_reg  in  4  destination register index.
- i_dest_addr  in  ADDRESS_WIDTH  destination memory address (stores only).
- o_ready  out  1  packet accepted on an edge where i_res_valid && o_ready; drives execute i_next_ready.
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  4  register-file write index.
- o_rf_wdata  out  DATA_WIDTH  register-file write data.
- o_mem_req  out  1  memory store request.
- o_mem_addr  out  ADDRESS_WIDTH  store address.
- o_mem_wdata  out  DATA_WIDTH  store data.
- i_mem_ack  in  1  store accepted; sampled only while o_mem_req = 1.
- o_retire_count  out  RETIRE_WIDTH  number of retired packets.
- o_mem_err  out  1  sticky: a store timed out.
- o_busy  out  1  FIFO non-empty or FSM not in ST_IDLE.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FIFO empty; FSM in ST_IDLE.
  - o_rf_we, o_mem_req, o_mem_err, o_busy = 0; o_retire_count = 0.
  - o_rf_waddr, o_rf_wdata, o_mem_addr, o_mem_wdata = 0.
  - o_ready = 0 while reset is asserted, 1 from the first edge after release.
- Reset mid-operation: all in-flight and buffered packets are discarded. Outputs reach reset values immediately, without waiting for a clock edge.
- Packet classification, decoded from the FIFO head:
  - opcode == 8'h00: NOP.
  - opcode[7] == 1: memory store (address = dest_addr, data = res).
  - Otherwise: register write.
- FIFO:
  - Depth 2; all outputs registered.
  - o_ready = !full. A push is never accepted while full, even if a pop occurs on the same edge.
  - Push and pop on the same edge when not full: count unchanged, order preserved.
- FSM states:
  - ST_IDLE
  - ST_REG_WR: o_rf_we = 1 for exactly one cycle. Pop and retire at the end of the cycle.
  - ST_MEM_REQ: o_mem_req = 1, with o_mem_addr / o_mem_wdata held stable until exit.
- FSM transitions:
  - ST_IDLE with FIFO non-empty: go to ST_REG_WR (register write), ST_MEM_REQ (store), or pop and retire with no output activity (NOP).
  - ST_REG_WR, on its exit edge: if the FIFO holds another entry after the pop, decode it directly into the next state; otherwise go to ST_IDLE.
  - ST_MEM_REQ with i_mem_ack = 1 on an edge: pop, retire, o_mem_req = 0, then decode the next entry as above.
  - ST_MEM_REQ with no ack after MEM_TIMEOUT cycles: pop without retiring, o_mem_req = 0, o_mem_err = 1 (cleared only by reset).
  - An ack arriving on the same edge the timeout expires counts as an ack.
- Register index 0 is hardwired zero:
  - A register write with dest_reg = 0 passes through ST_REG_WR with o_rf_we = 0.
  - It still pops and retires.
- Latency:
  - A packet accepted at edge E0 is decoded at E1.
  - Register write: o_rf_we is high from E1 to E2.
  - Sustained throughput is one register write per cycle, with o_ready held high.
- o_retire_count increments by 1 per retired packet and wraps from all-ones to 0.

Test Plan:
- XOR packet (opcode 8'h01, res 32'h0000_00FF, dest_reg 3), single cycle of valid → o_rf_we high for exactly one cycle, beginning one cycle after acceptance, with waddr 3 and wdata 32'hFF; then o_retire_count = 1 and o_busy = 0.
- Three back-to-back register packets, valid held high → o_rf_we high on 3 consecutive cycles, in order; o_ready never drops; o_retire_count = 3.
- Store (opcode 8'h80, addr 16'h0040, data 32'hDEAD_BEEF) acked 5 cycles after req, while 2 register packets follow:
  - o_mem_req held 5 cycles with addr/data stable.
  - o_ready low once the FIFO is full.
  - The register writes follow the ack on consecutive cycles.
  - o_retire_count = 3.
- Register packet with dest_reg 0, plus a NOP → no o_rf_we pulse; o_retire_count increments by 2.
- Store never acked, MEM_TIMEOUT = 16 → o_mem_req high 16 cycles then low; o_mem_err = 1 and stays 1; o_retire_count unchanged; the next queued packet is processed normally.
- reset driven low mid-way through ST_MEM_REQ with the FIFO full → o_mem_req, o_busy and o_ready drop with no clock edge; o_retire_count = 0. After release: o_ready = 1 and no stale writes or requests are issued.
